// File: rtl/seletor_minigame_pkg.sv
// Shared constants for the minigame selector: menu FSM codes, mux select codes
// and the one-hot start-pulse decode used by the selector and display logic.
package seletor_minigame_pkg;

    localparam logic [3:0] ST_INICIAL = 4'h0;
    localparam logic [3:0] ST_MENU    = 4'h1;
    localparam logic [3:0] ST_LANCA   = 4'h2;
    localparam logic [3:0] ST_JOGANDO = 4'h3;
    localparam logic [3:0] ST_FIM     = 4'h4;

    localparam logic [1:0] MG_JOGO0 = 2'b00;
    localparam logic [1:0] MG_JOGO1 = 2'b01;
    localparam logic [1:0] MG_JOGO2 = 2'b10;
    localparam logic [1:0] MG_MENU  = 2'b11;

    function automatic logic [2:0] one_hot_jogo(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            MG_JOGO0: oh = 3'b001;
            MG_JOGO1: oh = 3'b010;
            MG_JOGO2: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seletor_minigame_detector_borda.sv
// Level-to-pulse rising-edge detector. History resets to 1 so a button held
// through reset does not produce a spurious edge when reset is released.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic nivel,
    output logic pulso
);

    logic anterior;

    always_ff @(posedge clock) begin
        if (!reset) begin
            anterior <= 1'b1;
        end else begin
            anterior <= nivel;
        end
    end

    assign pulso = nivel & ~anterior;

endmodule

// File: rtl/seletor_minigame.sv
// Menu/selection controller: walks a cursor over the minigames, launches the
// chosen one, waits for its pronto, holds the result on screen, then returns.
module seletor_minigame
    import seletor_minigame_pkg::*;
#(
    parameter int N_JOGOS     = 3,
    parameter int HOLD_CICLOS = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       botao_prox,
    input  logic       botao_conf,
    input  logic       botao_voltar,
    input  logic       pronto_in,
    output logic [1:0] minigame,
    output logic [3:0] estado_inicial,
    output logic [1:0] cursor,
    output logic [2:0] iniciar,
    output logic       zera_jogos
);

    localparam int             CW         = $clog2(HOLD_CICLOS + 1);
    localparam logic [CW-1:0]  HOLD_LOAD  = CW'(HOLD_CICLOS - 1);
    localparam logic [1:0]     CURSOR_MAX = 2'(N_JOGOS - 1);

    logic ev_prox, ev_conf, ev_voltar;

    detector_borda u_borda_prox (
        .clock (clock),
        .reset (reset),
        .nivel (botao_prox),
        .pulso (ev_prox)
    );

    detector_borda u_borda_conf (
        .clock (clock),
        .reset (reset),
        .nivel (botao_conf),
        .pulso (ev_conf)
    );

    detector_borda u_borda_voltar (
        .clock (clock),
        .reset (reset),
        .nivel (botao_voltar),
        .pulso (ev_voltar)
    );

    logic [3:0]    state, state_n;
    logic [1:0]    cursor_n;
    logic [CW-1:0] count, count_n;
    logic [2:0]    iniciar_n;
    logic          zera_n;
    logic [1:0]    minigame_n;

    always_comb begin
        state_n    = state;
        cursor_n   = cursor;
        count_n    = count;
        iniciar_n  = 3'b000;
        zera_n     = 1'b0;
        minigame_n = MG_MENU;

        case (state)
            ST_INICIAL: begin
                if (ev_conf) state_n = ST_MENU;
            end
            ST_MENU: begin
                // conf takes priority so a simultaneous prox cannot move the launched game
                if (ev_conf) begin
                    state_n = ST_LANCA;
                end else if (ev_voltar) begin
                    state_n = ST_INICIAL;
                end else if (ev_prox) begin
                    cursor_n = (cursor == CURSOR_MAX) ? 2'b00 : cursor + 2'b01;
                end
            end
            ST_LANCA: begin
                state_n = ST_JOGANDO;
            end
            ST_JOGANDO: begin
                if (pronto_in) begin
                    state_n = ST_FIM;
                    count_n = HOLD_LOAD;
                end else if (ev_voltar) begin
                    state_n = ST_MENU;
                    zera_n  = 1'b1;
                end
            end
            ST_FIM: begin
                if (ev_conf || ev_voltar || count == '0) begin
                    state_n = ST_MENU;
                    count_n = '0;
                end else begin
                    count_n = count - 1'b1;
                end
            end
            default: begin
                state_n = ST_INICIAL;
            end
        endcase

        if (state_n == ST_LANCA) iniciar_n = one_hot_jogo(cursor_n);

        if (state_n == ST_LANCA || state_n == ST_JOGANDO || state_n == ST_FIM) begin
            minigame_n = cursor_n;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_INICIAL;
            cursor     <= 2'b00;
            count      <= '0;
            iniciar    <= 3'b000;
            zera_jogos <= 1'b0;
            minigame   <= MG_MENU;
        end else begin
            state      <= state_n;
            cursor     <= cursor_n;
            count      <= count_n;
            iniciar    <= iniciar_n;
            zera_jogos <= zera_n;
            minigame   <= minigame_n;
        end
    end

    assign estado_inicial = state;

endmodule

// File: tb/tb_seletor_minigame.sv
// Self-checking bench for seletor_minigame (N_JOGOS=3, HOLD_CICLOS=8): each
// scenario is a table of per-cycle inputs and the outputs expected after that edge.
module tb_seletor_minigame;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       botao_prox = 1'b0;
    logic       botao_conf = 1'b0;
    logic       botao_voltar = 1'b0;
    logic       pronto_in = 1'b0;
    logic [1:0] minigame;
    logic [3:0] estado_inicial;
    logic [1:0] cursor;
    logic [2:0] iniciar;
    logic       zera_jogos;

    int compared   = 0;
    int mismatched = 0;

    logic [11:0] sb [$];

    seletor_minigame #(
        .N_JOGOS     (3),
        .HOLD_CICLOS (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .botao_prox     (botao_prox),
        .botao_conf     (botao_conf),
        .botao_voltar   (botao_voltar),
        .pronto_in      (pronto_in),
        .minigame       (minigame),
        .estado_inicial (estado_inicial),
        .cursor         (cursor),
        .iniciar        (iniciar),
        .zera_jogos     (zera_jogos)
    );

    always #5 clock = ~clock;

    // stimulus bits: {reset, prox, conf, voltar, pronto}
    localparam logic [4:0] S_IDLE = 5'b10000;
    localparam logic [4:0] S_PROX = 5'b11000;
    localparam logic [4:0] S_CONF = 5'b10100;
    localparam logic [4:0] S_VOLT = 5'b10010;
    localparam logic [4:0] S_PRON = 5'b10001;
    localparam logic [4:0] S_RST  = 5'b00000;

    function automatic logic [11:0] e(input logic [3:0] st, input logic [1:0] mg,
                                      input logic [1:0] cur, input logic [2:0] ini,
                                      input logic z);
        return {st, mg, cur, ini, z};
    endfunction

    function automatic logic [11:0] observed();
        return {estado_inicial, minigame, cursor, iniciar, zera_jogos};
    endfunction

    task automatic test_reset();
        logic [16:0] tbl [6];
        logic [11:0] want, got;
        tbl = '{
            {5'b00100, e(4'h0, 2'b11, 2'd0, 3'b000, 1'b0)},
            {5'b10100, e(4'h0, 2'b11, 2'd0, 3'b000, 1'b0)},
            {5'b10100, e(4'h0, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_IDLE,   e(4'h0, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_CONF,   e(4'h1, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_IDLE,   e(4'h1, 2'b11, 2'd0, 3'b000, 1'b0)}
        };
        foreach (tbl[i]) begin
            {reset, botao_prox, botao_conf, botao_voltar, pronto_in} = tbl[i][16:12];
            sb.push_back(tbl[i][11:0]);
            @(posedge clock); #1;
            want = sb.pop_front();
            got  = observed();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL test_reset step %0d: got {st,mg,cur,ini,zera}=%h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_cursor_wrap();
        logic [16:0] tbl [12];
        logic [11:0] want, got;
        tbl = '{
            {S_PROX,          e(4'h1, 2'b11, 2'd1, 3'b000, 1'b0)},
            {S_IDLE,          e(4'h1, 2'b11, 2'd1, 3'b000, 1'b0)},
            {S_PROX,          e(4'h1, 2'b11, 2'd2, 3'b000, 1'b0)},
            {S_IDLE,          e(4'h1, 2'b11, 2'd2, 3'b000, 1'b0)},
            {S_PROX,          e(4'h1, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_IDLE,          e(4'h1, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_PROX,          e(4'h1, 2'b11, 2'd1, 3'b000, 1'b0)},
            {S_IDLE,          e(4'h1, 2'b11, 2'd1, 3'b000, 1'b0)},
            {S_PROX | S_CONF, e(4'h2, 2'b01, 2'd1, 3'b010, 1'b0)},
            {S_IDLE,          e(4'h3, 2'b01, 2'd1, 3'b000, 1'b0)},
            {S_VOLT,          e(4'h1, 2'b11, 2'd1, 3'b000, 1'b1)},
            {S_IDLE,          e(4'h1, 2'b11, 2'd1, 3'b000, 1'b0)}
        };
        foreach (tbl[i]) begin
            {reset, botao_prox, botao_conf, botao_voltar, pronto_in} = tbl[i][16:12];
            sb.push_back(tbl[i][11:0]);
            @(posedge clock); #1;
            want = sb.pop_front();
            got  = observed();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL test_cursor_wrap step %0d: got {st,mg,cur,ini,zera}=%h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_launch();
        logic [16:0] tbl [6];
        logic [11:0] want, got;
        tbl = '{
            {S_PROX,          e(4'h1, 2'b11, 2'd2, 3'b000, 1'b0)},
            {S_IDLE,          e(4'h1, 2'b11, 2'd2, 3'b000, 1'b0)},
            {S_CONF,          e(4'h2, 2'b10, 2'd2, 3'b100, 1'b0)},
            {S_IDLE,          e(4'h3, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_PROX | S_CONF, e(4'h3, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_IDLE,          e(4'h3, 2'b10, 2'd2, 3'b000, 1'b0)}
        };
        foreach (tbl[i]) begin
            {reset, botao_prox, botao_conf, botao_voltar, pronto_in} = tbl[i][16:12];
            sb.push_back(tbl[i][11:0]);
            @(posedge clock); #1;
            want = sb.pop_front();
            got  = observed();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL test_launch step %0d: got {st,mg,cur,ini,zera}=%h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_hold();
        logic [16:0] tbl [11];
        logic [11:0] want, got;
        tbl = '{
            {S_PRON, e(4'h4, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_IDLE, e(4'h4, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_PRON, e(4'h4, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_IDLE, e(4'h4, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_IDLE, e(4'h4, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_IDLE, e(4'h4, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_IDLE, e(4'h4, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_IDLE, e(4'h4, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_IDLE, e(4'h1, 2'b11, 2'd2, 3'b000, 1'b0)},
            {S_PRON, e(4'h1, 2'b11, 2'd2, 3'b000, 1'b0)},
            {S_IDLE, e(4'h1, 2'b11, 2'd2, 3'b000, 1'b0)}
        };
        foreach (tbl[i]) begin
            {reset, botao_prox, botao_conf, botao_voltar, pronto_in} = tbl[i][16:12];
            sb.push_back(tbl[i][11:0]);
            @(posedge clock); #1;
            want = sb.pop_front();
            got  = observed();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL test_hold step %0d: got {st,mg,cur,ini,zera}=%h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_abort();
        logic [16:0] tbl [10];
        logic [11:0] want, got;
        tbl = '{
            {S_CONF,          e(4'h2, 2'b10, 2'd2, 3'b100, 1'b0)},
            {S_IDLE,          e(4'h3, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_VOLT,          e(4'h1, 2'b11, 2'd2, 3'b000, 1'b1)},
            {S_IDLE,          e(4'h1, 2'b11, 2'd2, 3'b000, 1'b0)},
            {S_CONF,          e(4'h2, 2'b10, 2'd2, 3'b100, 1'b0)},
            {S_IDLE,          e(4'h3, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_VOLT | S_PRON, e(4'h4, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_IDLE,          e(4'h4, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_CONF,          e(4'h1, 2'b11, 2'd2, 3'b000, 1'b0)},
            {S_IDLE,          e(4'h1, 2'b11, 2'd2, 3'b000, 1'b0)}
        };
        foreach (tbl[i]) begin
            {reset, botao_prox, botao_conf, botao_voltar, pronto_in} = tbl[i][16:12];
            sb.push_back(tbl[i][11:0]);
            @(posedge clock); #1;
            want = sb.pop_front();
            got  = observed();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL test_abort step %0d: got {st,mg,cur,ini,zera}=%h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_midgame();
        logic [16:0] tbl [18];
        logic [11:0] want, got;
        tbl = '{
            {S_CONF, e(4'h2, 2'b10, 2'd2, 3'b100, 1'b0)},
            {S_IDLE, e(4'h3, 2'b10, 2'd2, 3'b000, 1'b0)},
            {S_RST,  e(4'h0, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_IDLE, e(4'h0, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_CONF, e(4'h1, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_IDLE, e(4'h1, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_PROX, e(4'h1, 2'b11, 2'd1, 3'b000, 1'b0)},
            {S_IDLE, e(4'h1, 2'b11, 2'd1, 3'b000, 1'b0)},
            {S_CONF, e(4'h2, 2'b01, 2'd1, 3'b010, 1'b0)},
            {S_IDLE, e(4'h3, 2'b01, 2'd1, 3'b000, 1'b0)},
            {S_PRON, e(4'h4, 2'b01, 2'd1, 3'b000, 1'b0)},
            {S_IDLE, e(4'h4, 2'b01, 2'd1, 3'b000, 1'b0)},
            {S_RST,  e(4'h0, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_IDLE, e(4'h0, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_CONF, e(4'h1, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_IDLE, e(4'h1, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_VOLT, e(4'h0, 2'b11, 2'd0, 3'b000, 1'b0)},
            {S_IDLE, e(4'h0, 2'b11, 2'd0, 3'b000, 1'b0)}
        };
        foreach (tbl[i]) begin
            {reset, botao_prox, botao_conf, botao_voltar, pronto_in} = tbl[i][16:12];
            sb.push_back(tbl[i][11:0]);
            @(posedge clock); #1;
            want = sb.pop_front();
            got  = observed();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL test_reset_midgame step %0d: got {st,mg,cur,ini,zera}=%h required %h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cursor_wrap();
        test_launch();
        test_hold();
        test_abort();
        test_reset_midgame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
